// File: rtl/config_writer.sv
// ----------------------------------------------------------------------------
// config_writer
//
// Host-side write master for the parameter-configuration bus. Host commands
// (address, data, last) are buffered in a FIFO and issued as single-cycle bus
// writes. Consecutive writes are separated by at least GAP idle cycles. No new
// write starts while busy_in is high. A write that has already started always
// completes.
//
// Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is low during reset and while flush is high. It is also low when
// the FIFO holds DEPTH entries. The host may hold cmd_valid and change the
// payload only after an accepting edge.
//
// Ports
//   clk100                 system clock
//   reset                  asynchronous active-low reset
//   cmd_valid/cmd_ready    host command handshake
//   cmd_addr/cmd_data      parameter address / value
//   cmd_last               command ends a batch
//   flush                  synchronous clear of queued commands
//   busy_in                measurement active, hold off new writes
//   MEM_sdi_mem_S_*        registered bus write (address, strobe, data)
//   batch_done             1-cycle pulse after a write whose entry had last=1
//   fifo_count             number of queued entries
//   write_count            writes issued, wraps at 16 bits
//   dbg_state              current FSM state (0=IDLE, 1=WRITE, 2=GAP)
// ----------------------------------------------------------------------------
module config_writer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 33,
    parameter int GAP    = 1
) (
    input  logic                     clk100,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic                     cmd_last,
    input  logic                     flush,
    input  logic                     busy_in,
    output logic [ADDR_W-1:0]        MEM_sdi_mem_S_address,
    output logic                     MEM_sdi_mem_S_wrEn,
    output logic [DATA_W-1:0]        MEM_sdi_mem_S_wrData,
    output logic                     batch_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              write_count,
    output logic [1:0]               dbg_state
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int ENT_W      = 1 + ADDR_W + DATA_W;
    localparam int GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LOAD_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_LOAD_I[GAP_W-1:0];
    localparam logic [PTR_W:0]   FULL_COUNT = DEPTH[PTR_W:0];
    localparam bit               GAP_ZERO   = (GAP == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_ready_en;

    logic [ENT_W-1:0]  w_head;
    logic              w_head_last;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_push;
    logic              w_slot;
    logic              w_start;

    // ------------------------------------------------------------------
    // FSM / bus registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_cur_last;
    logic              r_batch_done;
    logic [15:0]       r_write_count;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[ENT_W-1];
    assign w_head_addr = w_head[DATA_W +: ADDR_W];
    assign w_head_data = w_head[DATA_W-1:0];

    // r_ready_en keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = r_ready_en && (r_count < FULL_COUNT) && !flush;
    assign w_push    = cmd_valid && cmd_ready;

    // Cycles in which the FSM may launch a write. The last GAP cycle counts
    // as a launch slot, so successive strobes are exactly GAP+1 cycles apart.
    assign w_slot  = (r_state == S_IDLE) ||
                     ((r_state == S_WRITE) && GAP_ZERO) ||
                     ((r_state == S_GAP) && (r_gap_cnt == '0));
    assign w_start = w_slot && (r_count != '0) && !busy_in && !flush;

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_last, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // cmd_ready is low during flush, so no push can collide with the clear.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_start) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_start})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_gap_cnt     <= '0;
            r_wren        <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_cur_last    <= 1'b0;
            r_batch_done  <= 1'b0;
            r_write_count <= '0;
        end else begin
            r_wren       <= 1'b0;
            r_batch_done <= 1'b0;
            if (r_state == S_WRITE) begin
                r_batch_done <= r_cur_last;
            end
            if (w_start) begin
                r_state       <= S_WRITE;
                r_wren        <= 1'b1;
                r_addr        <= w_head_addr;
                r_data        <= w_head_data;
                r_cur_last    <= w_head_last;
                r_write_count <= r_write_count + 16'd1;
            end else begin
                case (r_state)
                    S_WRITE: begin
                        if (GAP_ZERO) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign MEM_sdi_mem_S_address = r_addr;
    assign MEM_sdi_mem_S_wrEn    = r_wren;
    assign MEM_sdi_mem_S_wrData  = r_data;
    assign batch_done            = r_batch_done;
    assign fifo_count            = r_count;
    assign write_count           = r_write_count;
    assign dbg_state             = r_state;

endmodule

// File: tb/tb_config_writer.sv
`timescale 1ns/1ps
module tb_config_writer;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 33;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int ENT_W  = ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;
    logic rst_n;

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT with GAP=1 ----------------
    logic              v1, l1, f1, b1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              ready1, wren1, bd1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic [CNT_W-1:0]  fifo1;
    logic [15:0]       wc1;
    logic [1:0]        st1;

    config_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP(1)) dut1 (
        .clk100(clk100), .reset(rst_n),
        .cmd_valid(v1), .cmd_ready(ready1), .cmd_addr(a1), .cmd_data(d1),
        .cmd_last(l1), .flush(f1), .busy_in(b1),
        .MEM_sdi_mem_S_address(addr1), .MEM_sdi_mem_S_wrEn(wren1),
        .MEM_sdi_mem_S_wrData(data1), .batch_done(bd1),
        .fifo_count(fifo1), .write_count(wc1), .dbg_state(st1)
    );

    // ---------------- DUT with GAP=0 ----------------
    logic              v0, l0, f0, b0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              ready0, wren0, bd0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic [CNT_W-1:0]  fifo0;
    logic [15:0]       wc0;
    logic [1:0]        st0;

    config_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP(0)) dut0 (
        .clk100(clk100), .reset(rst_n),
        .cmd_valid(v0), .cmd_ready(ready0), .cmd_addr(a0), .cmd_data(d0),
        .cmd_last(l0), .flush(f0), .busy_in(b0),
        .MEM_sdi_mem_S_address(addr0), .MEM_sdi_mem_S_wrEn(wren0),
        .MEM_sdi_mem_S_wrData(data0), .batch_done(bd0),
        .fifo_count(fifo0), .write_count(wc0), .dbg_state(st0)
    );

    // ---------------- bus monitors (sample on falling edge) ----------------
    logic [ENT_W-1:0] obs1_q[$];
    int               obs1_cyc[$];
    int               bd1_cyc[$];
    logic [ENT_W-1:0] obs0_q[$];
    int               obs0_cyc[$];
    int               bd0_cnt = 0;
    int               wr0_total = 0;
    bit               log0 = 1'b1;

    always @(negedge clk100) begin
        if (wren1 === 1'b1) begin
            obs1_q.push_back({addr1, data1});
            obs1_cyc.push_back(cyc);
        end
        if (bd1 === 1'b1) bd1_cyc.push_back(cyc);
        if (wren0 === 1'b1) begin
            wr0_total = wr0_total + 1;
            if (log0) begin
                obs0_q.push_back({addr0, data0});
                obs0_cyc.push_back(cyc);
            end
        end
        if (bd0 === 1'b1) bd0_cnt = bd0_cnt + 1;
    end

    logic [ENT_W-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic clear1();
        obs1_q.delete();
        obs1_cyc.delete();
        bd1_cyc.delete();
        exp_q.delete();
    endtask

    task automatic clear0();
        obs0_q.delete();
        obs0_cyc.delete();
        exp_q.delete();
    endtask

    // Presents one command and advances one edge; valid is left high.
    task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic l);
        v1 = 1'b1; a1 = a; d1 = d; l1 = l;
        tick();
    endtask

    task automatic push0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic l);
        v0 = 1'b1; a0 = a; d0 = d; l0 = l;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 0; l1 = 0; f1 = 0; b1 = 0; a1 = '0; d1 = '0;
        v0 = 0; l0 = 0; f0 = 0; b0 = 0; a0 = '0; d0 = '0;
        repeat (3) tick();
        checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL reset_wren: got %0h expected 0", wren1); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h expected 0", ready1); end
        checks++; if (fifo1 !== '0) begin errors++; $display("FAIL reset_fifo: got %0h expected 0", fifo1); end
        checks++; if (wc1 !== 16'h0) begin errors++; $display("FAIL reset_wcount: got %0h expected 0", wc1); end
        checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0h expected 0", st1); end
        rst_n = 1'b1;
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %0h expected 0", ready1); end
        tick();
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %0h expected 1", ready1); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL ready0_after_edge: got %0h expected 1", ready0); end
    endtask

    task automatic test_gap_burst();
        int push_edge;
        clear1();
        exp_q.push_back({14'h0001, 33'd5});
        exp_q.push_back({14'h0002, 33'd7});
        exp_q.push_back({14'h0003, 33'd9});
        push1(14'h0001, 33'd5, 1'b0);
        push_edge = cyc;
        push1(14'h0002, 33'd7, 1'b0);
        push1(14'h0003, 33'd9, 1'b1);
        v1 = 1'b0; l1 = 1'b0;
        repeat (10) tick();
        checks++; if (obs1_q.size() != 3) begin errors++; $display("FAIL burst_count: got %0d expected 3", obs1_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < obs1_q.size()) begin
                checks++; if (obs1_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_write%0d: got %0h expected %0h", i, obs1_q[i], exp_q[i]); end
            end
        end
        if (obs1_cyc.size() == 3) begin
            checks++; if (obs1_cyc[0] != push_edge + 1) begin errors++; $display("FAIL first_latency: got %0d expected %0d", obs1_cyc[0], push_edge + 1); end
            checks++; if (obs1_cyc[1] - obs1_cyc[0] != 2) begin errors++; $display("FAIL spacing_1: got %0d expected 2", obs1_cyc[1] - obs1_cyc[0]); end
            checks++; if (obs1_cyc[2] - obs1_cyc[1] != 2) begin errors++; $display("FAIL spacing_2: got %0d expected 2", obs1_cyc[2] - obs1_cyc[1]); end
            checks++; if (bd1_cyc.size() != 1) begin errors++; $display("FAIL batch_count: got %0d expected 1", bd1_cyc.size()); end
            else begin
                checks++; if (bd1_cyc[0] != obs1_cyc[2] + 1) begin errors++; $display("FAIL batch_timing: got %0d expected %0d", bd1_cyc[0], obs1_cyc[2] + 1); end
            end
        end
        checks++; if (wc1 !== 16'd3) begin errors++; $display("FAIL burst_wcount: got %0d expected 3", wc1); end
    endtask

    task automatic test_busy_full();
        clear1();
        b1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push1(14'(16 + i), 33'(256 + i), 1'b0);
            if (i < 8) exp_q.push_back({14'(16 + i), 33'(256 + i)});
            if (i == 7) begin
                checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h expected 0", ready1); end
                checks++; if (fifo1 !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", fifo1); end
            end
        end
        v1 = 1'b0;
        checks++; if (fifo1 !== 4'd8) begin errors++; $display("FAIL full_ignore_push: got %0d expected 8", fifo1); end
        checks++; if (obs1_q.size() != 0) begin errors++; $display("FAIL busy_no_write: got %0d expected 0", obs1_q.size()); end
        b1 = 1'b0;
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL ready_before_pop: got %0h expected 0", ready1); end
        tick();
        checks++; if (wren1 !== 1'b1) begin errors++; $display("FAIL busy_release_wren: got %0h expected 1", wren1); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %0h expected 1", ready1); end
        checks++; if (fifo1 !== 4'd7) begin errors++; $display("FAIL count_after_pop: got %0d expected 7", fifo1); end
        repeat (20) tick();
        checks++; if (obs1_q.size() != 8) begin errors++; $display("FAIL drain_count: got %0d expected 8", obs1_q.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < obs1_q.size()) begin
                checks++; if (obs1_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_write%0d: got %0h expected %0h", i, obs1_q[i], exp_q[i]); end
            end
        end
        checks++; if (wc1 !== 16'd11) begin errors++; $display("FAIL drain_wcount: got %0d expected 11", wc1); end
        checks++; if (bd1_cyc.size() != 0) begin errors++; $display("FAIL drain_no_batch: got %0d expected 0", bd1_cyc.size()); end
    endtask

    task automatic test_flush();
        clear1();
        b1 = 1'b1;
        for (int i = 0; i < 5; i++) push1(14'(32 + i), 33'(512 + i), (i == 4));
        v1 = 1'b0; l1 = 1'b0;
        checks++; if (fifo1 !== 4'd5) begin errors++; $display("FAIL flush_queued: got %0d expected 5", fifo1); end
        b1 = 1'b0;
        tick();
        tick();
        tick();
        checks++; if ({wren1, addr1} !== {1'b1, 14'h21}) begin errors++; $display("FAIL flush_second_write: got %0h expected %0h", {wren1, addr1}, {1'b1, 14'h21}); end
        f1 = 1'b1;
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0h expected 0", ready1); end
        tick();
        f1 = 1'b0;
        checks++; if (fifo1 !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fifo1); end
        repeat (10) tick();
        checks++; if (obs1_q.size() != 2) begin errors++; $display("FAIL flush_writes: got %0d expected 2", obs1_q.size()); end
        if (obs1_q.size() == 2) begin
            checks++; if (obs1_q[1] !== {14'h21, 33'h201}) begin errors++; $display("FAIL flush_entry: got %0h expected %0h", obs1_q[1], {14'h21, 33'h201}); end
        end
        checks++; if (bd1_cyc.size() != 0) begin errors++; $display("FAIL flush_no_batch: got %0d expected 0", bd1_cyc.size()); end
        checks++; if (wc1 !== 16'd13) begin errors++; $display("FAIL flush_wcount: got %0d expected 13", wc1); end
    endtask

    task automatic test_back_to_back();
        log0 = 1'b1;
        clear0();
        b0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push0(14'(48 + i), 33'(768 + i), 1'b0);
            exp_q.push_back({14'(48 + i), 33'(768 + i)});
        end
        v0 = 1'b0;
        checks++; if (fifo0 !== 4'd4) begin errors++; $display("FAIL b2b_queued: got %0d expected 4", fifo0); end
        b0 = 1'b0;
        repeat (8) tick();
        checks++; if (obs0_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", obs0_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < obs0_q.size()) begin
                checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write%0d: got %0h expected %0h", i, obs0_q[i], exp_q[i]); end
                checks++; if (obs0_cyc[i] - obs0_cyc[0] != i) begin errors++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, obs0_cyc[i] - obs0_cyc[0], i); end
            end
        end
        // Second batch: raise busy_in right after the second strobe.
        clear0();
        b0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push0(14'(64 + i), 33'(1024 + i), 1'b0);
            exp_q.push_back({14'(64 + i), 33'(1024 + i)});
        end
        v0 = 1'b0;
        b0 = 1'b0;
        tick();
        tick();
        checks++; if (wren0 !== 1'b1) begin errors++; $display("FAIL stall_second_pulse: got %0h expected 1", wren0); end
        b0 = 1'b1;
        repeat (10) tick();
        checks++; if (obs0_q.size() != 2) begin errors++; $display("FAIL stall_writes: got %0d expected 2", obs0_q.size()); end
        checks++; if (fifo0 !== 4'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", fifo0); end
        b0 = 1'b0;
        repeat (6) tick();
        checks++; if (obs0_q.size() != 4) begin errors++; $display("FAIL resume_writes: got %0d expected 4", obs0_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < obs0_q.size()) begin
                checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL resume_write%0d: got %0h expected %0h", i, obs0_q[i], exp_q[i]); end
            end
        end
        checks++; if (wc0 !== 16'd8) begin errors++; $display("FAIL b2b_wcount: got %0d expected 8", wc0); end
    endtask

    task automatic test_reset_inflight();
        clear1();
        b1 = 1'b1;
        for (int i = 0; i < 4; i++) push1(14'(80 + i), 33'(1280 + i), 1'b0);
        v1 = 1'b0;
        b1 = 1'b0;
        tick();
        checks++; if (wren1 !== 1'b1) begin errors++; $display("FAIL inflight_wren: got %0h expected 1", wren1); end
        checks++; if (fifo1 !== 4'd3) begin errors++; $display("FAIL inflight_count: got %0d expected 3", fifo1); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL async_wren: got %0h expected 0", wren1); end
        checks++; if (bd1 !== 1'b0) begin errors++; $display("FAIL async_batch: got %0h expected 0", bd1); end
        checks++; if (fifo1 !== 4'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", fifo1); end
        checks++; if (wc1 !== 16'd0) begin errors++; $display("FAIL async_wcount: got %0d expected 0", wc1); end
        repeat (3) tick();
        rst_n = 1'b1;
        clear1();
        repeat (10) tick();
        checks++; if (obs1_q.size() != 0) begin errors++; $display("FAIL post_reset_writes: got %0d expected 0", obs1_q.size()); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0h expected 1", ready1); end
    endtask

    task automatic test_count_wrap();
        int  pushes;
        int  guard;
        bit  acc;
        log0 = 1'b0;
        wr0_total = 0;
        pushes = 0;
        guard = 0;
        b0 = 1'b0;
        l0 = 1'b0;
        v0 = 1'b1;
        while (pushes < 65535 && guard < 70000) begin
            a0 = pushes[13:0];
            d0 = 33'(pushes);
            acc = ready0;
            tick();
            if (acc) pushes++;
            guard++;
        end
        v0 = 1'b0;
        checks++; if (pushes != 65535) begin errors++; $display("FAIL wrap_pushes: got %0d expected 65535", pushes); end
        repeat (12) tick();
        checks++; if (wc0 !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0h expected ffff", wc0); end
        checks++; if (wr0_total != 65535) begin errors++; $display("FAIL wrap_strobes: got %0d expected 65535", wr0_total); end
        push0(14'h3FFF, 33'h1_0000_0000, 1'b0);
        v0 = 1'b0;
        repeat (5) tick();
        checks++; if (wc0 !== 16'h0000) begin errors++; $display("FAIL wrap_rollover: got %0h expected 0", wc0); end
        checks++; if (wr0_total != 65536) begin errors++; $display("FAIL wrap_last_strobe: got %0d expected 65536", wr0_total); end
    endtask

    initial begin
        test_reset();
        test_gap_burst();
        test_busy_full();
        test_flush();
        test_back_to_back();
        test_reset_inflight();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
